// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM PIO: data/direction/mask/edge-capture registers, synchronised inputs, level irq.
// Optional atomic output set/clear at addresses 4/5 when PIO_BITSET_EN is defined.
module avalon_pio_gen #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
`ifdef PIO_BITSET_EN
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
`endif

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] s1, s2, s3;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] data_rd;

  assign wr    = chipselect && !write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Bits above WIDTH are don't-care on writes.
  generate
    if (WIDTH < 32) begin : g_wr_hi
      logic unused_wr_hi;
      assign unused_wr_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Edge polarity is fixed at elaboration.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = s2 & ~s3;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~s2 & s3;
    end else begin : g_any
      assign edge_det = s2 ^ s3;
    end
  endgenerate

  assign edge_clr = (wr && (address == ADDR_EDGE)) ? wdata : '0;

  // Next output data: plain load, plus optional single-cycle set/clear.
  always_comb begin
    data_nxt = data_out;
    if (wr) begin
      case (address)
        ADDR_DATA:  data_nxt = wdata;
`ifdef PIO_BITSET_EN
        ADDR_SET:   data_nxt = data_out | wdata;
        ADDR_CLEAR: data_nxt = data_out & ~wdata;
`endif
        default:    data_nxt = data_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= RESET_VALUE;
      direction    <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      s3       <= s2;
      data_out <= data_nxt;
      if (wr && (address == ADDR_DIR))  direction <= wdata;
      if (wr && (address == ADDR_MASK)) irq_mask  <= wdata;
      // A new edge wins over a simultaneous write-1-to-clear.
      edge_capture <= (edge_capture & ~edge_clr) | edge_det;
    end
  end

  assign data_rd = (data_out & direction) | (s2 & ~direction);

  // Zero-latency read mux over registered state only.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA: readdata = 32'(data_rd);
      ADDR_DIR:  readdata = 32'(direction);
      ADDR_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE: readdata = 32'(edge_capture);
      default:   readdata = 32'd0;
    endcase
  end

  assign out_port = data_out;
  assign out_oe   = direction;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Self-checking bench for avalon_pio_gen (WIDTH=8, RESET_VALUE=8'hA5, rising edge capture).
module tb_avalon_pio_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  out_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] got;
  logic [31:0] exp_v;

  avalon_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_oe(out_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Read each address in a and compare against the scoreboard in order.
  task automatic read_and_score(input string nm, input logic [2:0] a);
    bus_read(a, got);
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL %s addr%0d got %h exp %h", nm, a, got, exp_v); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; in_port = 8'h3C;
    #12;
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL rst_out_port got %h exp a5", out_port); end
    checks++; if (out_oe !== 8'h00) begin errors++; $display("FAIL rst_out_oe got %h exp 00", out_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    @(posedge clk); #1; reset_n = 1'b1;
    tick();                               // edge N: s1 <= 3C
    sb.push_back(32'h0);
    read_and_score("rst_presync", 3'd0);
    tick();                               // edge N+1: in_sync = 3C
    sb.push_back(32'h3C); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    for (int i = 0; i < 4; i++) read_and_score("rst_map", 3'(i));
    tick();                               // edge N+2: rising edges from reset state captured
    sb.push_back(32'h3C);
    read_and_score("rst_cap_n2", 3'd3);
    bus_write(3'd3, 32'hFF);
    sb.push_back(32'h0);
    read_and_score("rst_cap_clr", 3'd3);
  endtask

  task automatic test_dir_data();
    in_port = 8'h0F;
    bus_write(3'd1, 32'hFFFF_FFF0);
    bus_write(3'd0, 32'h0000_005A);
    tick(); tick();
    checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL dd_out_port got %h exp 5a", out_port); end
    checks++; if (out_oe !== 8'hF0) begin errors++; $display("FAIL dd_out_oe got %h exp f0", out_oe); end
    sb.push_back(32'h5F); sb.push_back(32'hF0);
    read_and_score("dd_data", 3'd0);
    read_and_score("dd_dir", 3'd1);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd1, 32'h00);
  endtask

  task automatic test_edge_irq();
    bus_write(3'd2, 32'h01);
    in_port = 8'h0E;
    repeat (4) tick();
    bus_write(3'd3, 32'hFF);
    sb.push_back(32'h0);
    read_and_score("ei_fall_ignored", 3'd3);
    in_port = 8'h0F;
    tick();                               // edge N
    tick();                               // edge N+1
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ei_irq_n1 got %b exp 0", irq); end
    sb.push_back(32'h0F);
    read_and_score("ei_sync_n1", 3'd0);
    tick();                               // edge N+2
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ei_irq_n2 got %b exp 1", irq); end
    sb.push_back(32'h01);
    read_and_score("ei_cap_n2", 3'd3);
    bus_write(3'd3, 32'h01);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ei_irq_clr got %b exp 0", irq); end
    // Captured but masked edge must not raise irq.
    bus_write(3'd2, 32'h00);
    in_port = 8'h0E; repeat (3) tick();
    in_port = 8'h0F; repeat (3) tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ei_irq_masked got %b exp 0", irq); end
    sb.push_back(32'h01);
    read_and_score("ei_cap_masked", 3'd3);
    bus_write(3'd3, 32'hFF);
  endtask

  task automatic test_clear_collision();
    bus_write(3'd2, 32'h04);
    in_port = 8'h0B;
    repeat (4) tick();
    bus_write(3'd3, 32'hFF);
    in_port = 8'h0F;
    tick(); tick();                       // edge on bit 2 now pending for edge N+2
    bus_write(3'd3, 32'h04);              // clear lands on edge N+2
    sb.push_back(32'h04);
    read_and_score("cc_cap_kept", 3'd3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cc_irq got %b exp 1", irq); end
    bus_write(3'd3, 32'h04);
    sb.push_back(32'h0);
    read_and_score("cc_cap_clr", 3'd3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cc_irq_clr got %b exp 0", irq); end
  endtask

  task automatic test_bitset();
    logic [7:0] e1, e2;
`ifdef PIO_BITSET_EN
    e1 = 8'h3F; e2 = 8'h3C;
`else
    e1 = 8'h0F; e2 = 8'h0F;
`endif
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'h30);
    checks++; if (out_port !== e1) begin errors++; $display("FAIL bs_set got %h exp %h", out_port, e1); end
    bus_write(3'd5, 32'h03);
    checks++; if (out_port !== e2) begin errors++; $display("FAIL bs_clr got %h exp %h", out_port, e2); end
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'h00);
    checks++; if (out_port !== e2) begin errors++; $display("FAIL bs_hi_ignored got %h exp %h", out_port, e2); end
    for (int i = 4; i < 8; i++) sb.push_back(32'h0);
    for (int i = 4; i < 8; i++) read_and_score("bs_rd_zero", 3'(i));
  endtask

  task automatic test_reset_async();
    bus_write(3'd1, 32'hFF);
    bus_write(3'd2, 32'hFF);
    bus_write(3'd0, 32'h12);
    in_port = 8'h00; repeat (4) tick();
    bus_write(3'd3, 32'hFF);
    in_port = 8'hFF; repeat (3) tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ra_irq_pre got %b exp 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ra_irq got %b exp 0", irq); end
    checks++; if (out_oe !== 8'h00) begin errors++; $display("FAIL ra_out_oe got %h exp 00", out_oe); end
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL ra_out_port got %h exp a5", out_port); end
    sb.push_back(32'h0); sb.push_back(32'h0);
    read_and_score("ra_cap", 3'd3);
    read_and_score("ra_mask", 3'd2);
    @(posedge clk); #1; reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_dir_data();
    test_edge_irq();
    test_clear_collision();
    test_bitset();
    test_reset_async();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
